intesn_sequencer: RTL

- Controller that sequences one integer Echo State Network reservoir datapath (cyclic-shift reservoir, per-neuron update, linear readout accumulator).
- Once armed, it accepts one input item per handshake and steps the datapath through four phases: load, LAYER reservoir update sweeps, one readout sweep, and output.
- Sits between the input sample source and the reservoir/readout datapath. It owns all datapath enables and the neuron address.

---
 rtl/intesn_pkg.sv | 11 +
 rtl/intesn_addr_counter.sv | 33 +++
 rtl/intesn_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/intesn_pkg.sv
// intesn_pkg: shared state encoding, width helper and default widths for the ESN sequencer
package intesn_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, LOAD, UPDATE, READOUT, OUTPUT} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int ADDR_W = clog2(4);
  localparam int LAYER_W = clog2(1) + 1;
endpackage

// File: rtl/intesn_addr_counter.sv
// intesn_addr_counter: neuron address counter that wraps at N-1 and steps the sweep index
module intesn_addr_counter
  import intesn_pkg::*;
#(
  parameter int N = 4,
  parameter int LAYERS = 1,
  parameter int AW = clog2(N),
  parameter int LW = clog2(LAYERS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic [LW-1:0] layer,
  output logic          last_neuron,
  output logic          last_sweep
);
  assign last_neuron = addr == AW'(N - 1);
  assign last_sweep = layer == LW'(LAYERS - 1);
  // clear wins over enable; the last sweep wraps the sweep index back to 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      layer <= '0;
    end else if (clr) begin
      addr <= '0;
      layer <= '0;
    end else if (en) begin
      addr <= last_neuron ? '0 : addr + AW'(1);
      layer <= last_neuron ? (last_sweep ? '0 : layer + LW'(1)) : layer;
    end
endmodule

// File: rtl/intesn_sequencer.sv
// intesn_sequencer: steps one ESN reservoir/readout datapath through load, update, readout and output
module intesn_sequencer
  import intesn_pkg::*;
#(
  parameter int RESERVOIR_SIZE = 4,
  parameter int IDATA_DEMENTION = 2,
  parameter int LAYER = 1,
  parameter int WASHOUT = 2,
  parameter int CNT_W = 8
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iStart,
  input  logic                                iStop,
  input  logic [IDATA_DEMENTION-1:0]          iItem,
  input  logic                                iItem_valid,
  output logic                                oItem_ready,
  output logic [IDATA_DEMENTION-1:0]          oItem,
  output logic                                oLoad,
  output logic                                oAcc_clr,
  output logic                                oUpdate_en,
  output logic [clog2(LAYER):0]               oLayer,
  output logic                                oAcc_en,
  output logic [clog2(RESERVOIR_SIZE)-1:0]    oNeuron_addr,
  output logic                                oOut_valid,
  input  logic                                iOut_ready,
  output logic                                oBusy,
  output logic [CNT_W-1:0]                    oSample_cnt
);
  state_t state, nxt;
  logic last_neuron, last_sweep;
  logic accept, in_washout, done;
  assign accept = state == ARMED && iItem_valid;
  assign in_washout = 32'(oSample_cnt) < 32'(WASHOUT);
  assign done = (state == READOUT && last_neuron && in_washout) || (state == OUTPUT && iOut_ready);
  assign oItem_ready = state == ARMED;
  assign oLoad = state == LOAD;
  assign oAcc_clr = state == LOAD;
  assign oUpdate_en = state == UPDATE;
  assign oAcc_en = state == READOUT;
  assign oOut_valid = state == OUTPUT;
  assign oBusy = state inside {LOAD, UPDATE, READOUT, OUTPUT};
  intesn_addr_counter #(.N(RESERVOIR_SIZE), .LAYERS(LAYER)) u_addr (
    .clk(iClk),
    .rst(iRst),
    .clr(iStop || accept || (state == READOUT && last_neuron)),
    .en(state == UPDATE || state == READOUT),
    .addr(oNeuron_addr),
    .layer(oLayer),
    .last_neuron(last_neuron),
    .last_sweep(last_sweep)
  );
  // state register
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) state <= IDLE;
    else state <= nxt;
  // next state; iStop overrides every other request
  always_comb begin
    nxt = state;
    if (iStop) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = iStart ? ARMED : IDLE;
        ARMED:   nxt = iItem_valid ? LOAD : ARMED;
        LOAD:    nxt = UPDATE;
        UPDATE:  nxt = (last_neuron && last_sweep) ? READOUT : UPDATE;
        READOUT: nxt = last_neuron ? (in_washout ? ARMED : OUTPUT) : READOUT;
        OUTPUT:  nxt = iOut_ready ? ARMED : OUTPUT;
        default: nxt = IDLE;
      endcase
  end
  // latched sample and saturating completed-sample count, both kept across a stop
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      oItem <= '0;
      oSample_cnt <= '0;
    end else if (!iStop) begin
      if (accept) oItem <= iItem;
      if (state == IDLE && iStart) oSample_cnt <= '0;
      else if (done) oSample_cnt <= &oSample_cnt ? oSample_cnt : oSample_cnt + CNT_W'(1);
    end
endmodule
